// File: rtl/fg_input_conditioner_if.sv
// Fast-gate conditioner bus: enable and raw opto input toward the
// conditioner, conditioned level/edge and measurement results back out.
interface fg_input_conditioner_if #(
   parameter int PERIOD_WIDTH = 24
);
   logic                    enable;
   logic                    fg_opto;
   logic                    fg_level;
   logic                    fg_rise;
   logic [PERIOD_WIDTH-1:0] fg_period;
   logic [PERIOD_WIDTH-1:0] fg_width;
   logic                    fg_locked;
   logic                    fg_lost;

   // Side that supplies the gate and consumes the conditioned results.
   modport master (
      output enable,
      output fg_opto,
      input  fg_level,
      input  fg_rise,
      input  fg_period,
      input  fg_width,
      input  fg_locked,
      input  fg_lost
   );

   // The conditioner itself.
   modport slave (
      input  enable,
      input  fg_opto,
      output fg_level,
      output fg_rise,
      output fg_period,
      output fg_width,
      output fg_locked,
      output fg_lost
   );
endinterface

// File: rtl/fg_input_conditioner.sv
// Fast-gate input conditioner: synchronizes and glitch-filters the raw opto
// line, emits a clean level and rise pulse, measures gate period and high
// time, and declares frequency lock once consecutive periods agree.
module fg_input_conditioner #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 8,
   parameter int PERIOD_WIDTH  = 24,
   parameter int PERIOD_TOL    = 2000,
   parameter int LOCK_COUNT    = 3
) (
   input logic                   clock,
   input logic                   reset_signal,
   fg_input_conditioner_if.slave bus
);

   localparam int FCNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam int MCNT_W = (LOCK_COUNT > 0) ? $clog2(LOCK_COUNT + 1) : 1;

   localparam logic [FCNT_W-1:0]       FCNT_LAST   = FCNT_W'(FILTER_CYCLES - 1);
   localparam logic [MCNT_W-1:0]       MATCH_LOCK  = MCNT_W'(LOCK_COUNT);
   localparam logic [PERIOD_WIDTH-1:0] CNT_MAX     = '1;
   localparam logic [PERIOD_WIDTH-1:0] CNT_ONE     = PERIOD_WIDTH'(1);
   localparam logic [PERIOD_WIDTH:0]   TOL_EXT     = (PERIOD_WIDTH + 1)'(PERIOD_TOL);
   localparam logic [PERIOD_WIDTH:0]   TIMEOUT_OFS = (PERIOD_WIDTH + 1)'(PERIOD_TOL + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACQUIRE,
      ST_SEED,
      ST_MEASURE,
      ST_LOCKED
   } state_t;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0]  sync_reg;
   logic [FCNT_W-1:0]       fcnt_reg;
   logic                    level_reg;
   logic                    rise_reg;

   logic [PERIOD_WIDTH-1:0] wcnt_reg;
   logic [PERIOD_WIDTH-1:0] width_reg;

   state_t                  state_reg;
   logic [PERIOD_WIDTH-1:0] pcnt_reg;
   logic [PERIOD_WIDTH-1:0] ref_reg;
   logic [PERIOD_WIDTH-1:0] period_reg;
   logic [MCNT_W-1:0]       match_cnt_reg;
   logic                    locked_reg;
   logic                    lost_reg;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic                    sync_bit;
   logic                    level_fall;
   logic [PERIOD_WIDTH-1:0] wcnt_cur;
   logic                    pcnt_sat;
   logic [PERIOD_WIDTH-1:0] pcnt_inc;
   logic [PERIOD_WIDTH:0]   pcnt_ext;
   logic [PERIOD_WIDTH:0]   ref_ext;
   logic [PERIOD_WIDTH:0]   period_diff;
   logic                    period_match;
   logic                    timeout_hit;
   logic [MCNT_W-1:0]       match_inc;
   logic                    pcnt_running;

   assign sync_bit = sync_reg[SYNC_STAGES-1];

   // The filter is about to clear the level: this is the last high cycle.
   assign level_fall = level_reg && !sync_bit && (fcnt_reg == FCNT_LAST);

   // High-time count including the current cycle; the rise cycle counts as 1.
   assign wcnt_cur = rise_reg ? CNT_ONE
                   : ((wcnt_reg == CNT_MAX) ? CNT_MAX : wcnt_reg + 1'b1);

   assign pcnt_sat = (pcnt_reg == CNT_MAX);
   assign pcnt_inc = pcnt_sat ? CNT_MAX : pcnt_reg + 1'b1;

   // Period comparison is done one bit wider so the subtraction cannot wrap.
   assign pcnt_ext     = {1'b0, pcnt_reg};
   assign ref_ext      = {1'b0, ref_reg};
   assign period_diff  = (pcnt_ext >= ref_ext) ? (pcnt_ext - ref_ext) : (ref_ext - pcnt_ext);
   assign period_match = (period_diff <= TOL_EXT);

   // A locked gate that has gone quiet past the tolerance window is lost.
   assign timeout_hit = (pcnt_ext == ref_ext + TIMEOUT_OFS);

   assign match_inc = match_cnt_reg + 1'b1;

   assign pcnt_running = (state_reg == ST_SEED) || (state_reg == ST_MEASURE)
                      || (state_reg == ST_LOCKED);

   // ------------------------------------------------------------------
   // Input synchronizer: shift the raw opto line through SYNC_STAGES flops.
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_signal) begin
      if (!reset_signal) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.fg_opto};
      end
   end

   // ------------------------------------------------------------------
   // Glitch filter: toggle the level after FILTER_CYCLES disagreeing samples.
   // Runs regardless of enable so the level always tracks the input.
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_signal) begin
      if (!reset_signal) begin
         fcnt_reg  <= '0;
         level_reg <= 1'b0;
         rise_reg  <= 1'b0;
      end else begin
         rise_reg <= 1'b0;
         if (sync_bit != level_reg) begin
            if (fcnt_reg == FCNT_LAST) begin
               fcnt_reg  <= '0;
               level_reg <= sync_bit;
               rise_reg  <= sync_bit;
            end else begin
               fcnt_reg <= fcnt_reg + 1'b1;
            end
         end else begin
            fcnt_reg <= '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // High-time measurement: count while level is high, capture on the fall.
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_signal) begin
      if (!reset_signal) begin
         wcnt_reg  <= '0;
         width_reg <= '0;
      end else if (!bus.enable) begin
         wcnt_reg  <= '0;
         width_reg <= '0;
      end else begin
         if (level_reg) begin
            wcnt_reg <= wcnt_cur;
         end
         if (level_fall) begin
            width_reg <= wcnt_cur;
         end
      end
   end

   // ------------------------------------------------------------------
   // Lock FSM with the period counter and all registered lock outputs.
   // A rise is always evaluated first, so a rise landing on the timeout
   // threshold is judged as a period rather than as a missing pulse.
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_signal) begin
      if (!reset_signal) begin
         state_reg     <= ST_IDLE;
         pcnt_reg      <= '0;
         ref_reg       <= '0;
         period_reg    <= '0;
         match_cnt_reg <= '0;
         locked_reg    <= 1'b0;
         lost_reg      <= 1'b0;
      end else if (!bus.enable) begin
         state_reg     <= ST_IDLE;
         pcnt_reg      <= '0;
         ref_reg       <= '0;
         period_reg    <= '0;
         match_cnt_reg <= '0;
         locked_reg    <= 1'b0;
         lost_reg      <= 1'b0;
      end else begin
         lost_reg <= 1'b0;

         // Rise-to-rise counter: 1 in the cycle after a rise, saturating.
         if (rise_reg) begin
            pcnt_reg <= CNT_ONE;
         end else if (pcnt_running) begin
            pcnt_reg <= pcnt_inc;
         end else begin
            pcnt_reg <= '0;
         end

         case (state_reg)
            ST_IDLE: begin
               locked_reg <= 1'b0;
               state_reg  <= ST_ACQUIRE;
            end

            ST_ACQUIRE: begin
               locked_reg <= 1'b0;
               if (rise_reg) begin
                  state_reg <= ST_SEED;
               end
            end

            ST_SEED: begin
               if (rise_reg) begin
                  state_reg     <= ST_MEASURE;
                  ref_reg       <= pcnt_reg;
                  period_reg    <= pcnt_reg;
                  match_cnt_reg <= '0;
               end else if (pcnt_sat) begin
                  state_reg     <= ST_ACQUIRE;
                  match_cnt_reg <= '0;
               end
            end

            ST_MEASURE: begin
               if (rise_reg) begin
                  period_reg <= pcnt_reg;
                  ref_reg    <= pcnt_reg;
                  if (period_match) begin
                     match_cnt_reg <= match_inc;
                     if (match_inc == MATCH_LOCK) begin
                        state_reg  <= ST_LOCKED;
                        locked_reg <= 1'b1;
                     end
                  end else begin
                     match_cnt_reg <= '0;
                  end
               end else if (pcnt_sat) begin
                  state_reg     <= ST_ACQUIRE;
                  match_cnt_reg <= '0;
               end
            end

            ST_LOCKED: begin
               if (rise_reg) begin
                  period_reg <= pcnt_reg;
                  ref_reg    <= pcnt_reg;
                  if (!period_match) begin
                     lost_reg      <= 1'b1;
                     locked_reg    <= 1'b0;
                     match_cnt_reg <= '0;
                     state_reg     <= ST_MEASURE;
                  end
               end else if (timeout_hit || pcnt_sat) begin
                  // Saturation also ends lock so a reference near full scale
                  // whose threshold is unreachable cannot hold lock forever.
                  lost_reg      <= 1'b1;
                  locked_reg    <= 1'b0;
                  match_cnt_reg <= '0;
                  state_reg     <= ST_ACQUIRE;
               end
            end

            default: begin
               state_reg  <= ST_IDLE;
               locked_reg <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs are driven straight from registers.
   // ------------------------------------------------------------------
   assign bus.fg_level  = level_reg;
   assign bus.fg_rise   = rise_reg;
   assign bus.fg_period = period_reg;
   assign bus.fg_width  = width_reg;
   assign bus.fg_locked = locked_reg;
   assign bus.fg_lost   = lost_reg;

endmodule

// File: doc/fg_input_conditioner.md
# fg_input_conditioner

Upstream conditioner for the raw fast-gate opto input feeding the experiment-phase FSM's `fg_signal`. It synchronizes and glitch-filters the asynchronous opto line, emits clean level and edge outputs, and measures gate period and open time. It also declares frequency lock once the gate train is stable, so the phase FSM only acts on a trustworthy fast gate.

## Interface
- `SYNC_STAGES`, 2, flip-flop stages in the input synchronizer (≥2).
- `FILTER_CYCLES`, 8, consecutive stable synchronized samples required before `fg_level` changes (≥1).
- `PERIOD_WIDTH`, 24, width of period and width counters (10 ms at 200 MHz = 2,000,000 fits).
- `PERIOD_TOL`, 2000, maximum |period − reference| in clocks counted as a match.
- `LOCK_COUNT`, 3, consecutive matching periods needed to assert lock (≥1).

- `clock` in 1: single system clock; all logic on rising edge.
- `reset_signal` in 1: asynchronous, active-low reset (0 = reset).
- `enable` in 1: synchronous enable; 0 forces IDLE and clears measurement state.
- `fg_opto` in 1: raw asynchronous fast-gate opto input.
- `fg_level` out 1: filtered, synchronized gate level; drives the phase FSM's `fg_signal`.
- `fg_rise` out 1: one-cycle pulse on each `fg_level` 0→1.
- `fg_period` out PERIOD_WIDTH: last captured rise-to-rise period in clocks.
- `fg_width` out PERIOD_WIDTH: last captured high time of `fg_level` in clocks.
- `fg_locked` out 1: gate train stable within tolerance.
- `fg_lost` out 1: one-cycle pulse when lock is dropped.

## Operation
- Synchronizer: `SYNC_STAGES` flops, reset to 0. The filter compares the synchronized bit with `fg_level`. If they differ for `FILTER_CYCLES` consecutive cycles, `fg_level` toggles. Any agreeing sample clears the filter count.
- `fg_rise` asserts in the same cycle `fg_level` goes 1.
- Width counter: cleared on `fg_rise`, increments while `fg_level`=1, saturates at all-ones. On the falling transition, `fg_width` ← count.
- Period counter `pcnt`: set to 1 in the cycle after `fg_rise`, then increments each cycle, saturating at all-ones. On a rise, captured period = `pcnt` (clocks between the two `fg_rise` pulses).
- Difference: |captured − `ref`| is computed in PERIOD_WIDTH+1 bits. It is a match iff ≤ `PERIOD_TOL`.
- FSM states: IDLE, ACQUIRE, SEED, MEASURE, LOCKED.
  - Any state with `enable`=0 → IDLE. This clears `ref`, `match_cnt`, `fg_locked`, `fg_period`, `fg_width`. Filtering continues.
  - IDLE, `enable`=1 → ACQUIRE.
  - ACQUIRE, `fg_rise` → SEED (start period counter).
  - SEED, `fg_rise` → MEASURE; `ref` ← period, `fg_period` ← period, `match_cnt` ← 0.
  - MEASURE, `fg_rise`: `fg_period` ← period. On a match, `match_cnt`+1; if it reaches `LOCK_COUNT`, go to LOCKED. On a miss, `match_cnt` ← 0. In both cases `ref` ← period.
  - LOCKED, `fg_rise` with match: `fg_period`/`ref` update and the state stays LOCKED.
  - LOCKED, `fg_rise` with miss: pulse `fg_lost`, go to MEASURE, `ref` ← period, `match_cnt` ← 0.
  - LOCKED, no rise and `pcnt` = `ref`+`PERIOD_TOL`+1: pulse `fg_lost`, go to ACQUIRE.
  - SEED/MEASURE with `pcnt` saturated: go to ACQUIRE, `match_cnt` ← 0.
- `fg_locked` = (state == LOCKED), registered.
- Simultaneous rise and timeout threshold in the same cycle: the rise wins and is evaluated as a period.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- Latency from raw `fg_opto` edge to `fg_level`/`fg_rise` is `SYNC_STAGES`+`FILTER_CYCLES` cycles (10 at default), ±1 for metastability resolution.
- `fg_period`, `fg_locked`, and `fg_lost` update 1 cycle after the `fg_rise` that triggers them.
- Reset asserted mid-operation returns everything to reset values immediately. After deassertion, at least 2 gate rises are needed before any `fg_period` is valid.
- `fg_lost` and `fg_rise` are never longer than one cycle.

## Test plan
Bench parameters: `FILTER_CYCLES`=8, `PERIOD_WIDTH`=16, `PERIOD_TOL`=4, `LOCK_COUNT`=3, `enable`=1.
- Glitch rejection: a 5-cycle high pulse on `fg_opto` -> `fg_level` stays 0, no `fg_rise`.
- Clean pulse: a 20-cycle high pulse -> `fg_rise` 10 cycles after the raw edge, `fg_width`=20.
- Lock: a 100-cycle period train with 20 cycles high -> `fg_period`=100 after rise #2, `fg_locked`=1 one cycle after rise #5.
- Out-of-tolerance: locked at 100, then one 110-cycle period -> `fg_lost` pulses, `fg_locked`=0, `fg_period`=110; relock after 3 further 110-cycle periods.
- Missing pulse: locked at 100, then `fg_opto` held low -> `fg_lost` when `pcnt`=105, state ACQUIRE, `fg_locked`=0.
- Reset/enable: assert `reset_signal`=0 while LOCKED -> all outputs 0 asynchronously. Separately, drop `enable` -> `fg_period`=0 and `fg_locked`=0 next cycle; `fg_level` keeps tracking the input.
